cntr8_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one cntr8 (8-bit loadable up/down counter driven by load/inc) between two requesters. A granted requester gets one burst: the arbiter loads its start value, applies LEN inc or dec commands, then returns the final count. Between bursts the arbiter holds the counter's value by reloading it.

---
 rtl/cntr8_arb.sv | 68 ++++++
 tb/tb_cntr8_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cntr8_arb.sv
// cntr8_arb: round-robin arbiter sequencing load/inc/dec bursts on one shared cntr8
module cntr8_arb #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       i_req,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_start0,
  input  logic [WIDTH-1:0] i_start1,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic [1:0]       o_grant,
  output logic [1:0]       o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_load,
  output logic             o_inc,
  output logic [WIDTH-1:0] o_d_in,
  input  logic [WIDTH-1:0] i_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic rr, op_l, win;
  logic [WIDTH-1:0] start_l;
  logic [LEN_W-1:0] len_l, step;
  assign win = (i_req == 2'b11) ? rr : i_req[1];
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? ((|i_req) ? LOAD : IDLE) :
               (state == LOAD) ? ((len_l != '0) ? RUN : DONE) :
               (state == RUN)  ? ((step == len_l - LEN_W'(1)) ? DONE : RUN) : IDLE;
  end
  always_comb begin
    o_load = (state != RUN);
    o_inc  = (state == RUN) & op_l;
    o_d_in = (state == LOAD) ? start_l : (state == DONE) ? i_cnt : o_result;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      o_grant  <= '0;
      o_done   <= '0;
      o_result <= '0;
      rr       <= 1'b0;
      op_l     <= 1'b0;
      start_l  <= '0;
      len_l    <= '0;
      step     <= '0;
    end else begin
      state  <= state_nx;
      o_done <= (state == DONE) ? o_grant : 2'b00;
      if (state == IDLE && |i_req) begin
        o_grant <= win ? 2'b10 : 2'b01;
        op_l    <= i_op[win];
        start_l <= win ? i_start1 : i_start0;
        len_l   <= win ? i_len1 : i_len0;
      end
      if (state == LOAD) step <= '0;
      if (state == RUN) step <= step + LEN_W'(1);
      if (state == DONE) begin
        o_result <= i_cnt;
        o_grant  <= 2'b00;
        rr       <= o_grant[0];
      end
    end
  end
endmodule

// File: tb/tb_cntr8_arb.sv
// tb_cntr8_arb: scoreboard bench for cntr8_arb driving a behavioural cntr8 model
module tb_cntr8_arb;
  logic clk = 0, reset_n = 0;
  logic [1:0] i_req = 0, i_op = 0, o_grant, o_done;
  logic [7:0] i_start0 = 0, i_start1 = 0, o_result, o_d_in, cnt = 0;
  logic [3:0] i_len0 = 0, i_len1 = 0;
  logic o_load, o_inc;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [1:0] m; logic [7:0] r; int t;} exp_t;
  exp_t sb[$];

  cntr8_arb dut (.clk(clk), .reset_n(reset_n), .i_req(i_req), .i_op(i_op),
    .i_start0(i_start0), .i_start1(i_start1), .i_len0(i_len0), .i_len1(i_len1),
    .o_grant(o_grant), .o_done(o_done), .o_result(o_result), .o_load(o_load),
    .o_inc(o_inc), .o_d_in(o_d_in), .i_cnt(cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) cnt <= o_load ? o_d_in : (o_inc ? cnt + 8'd1 : cnt - 8'd1);

  task automatic wait_done(input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = (o_done != 0);
    end
  endtask

  task automatic do_reset();
    i_req = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", o_grant); end
    total++; if (o_done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", o_done); end
    total++; if (o_result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", o_result); end
    total++; if (o_load !== 1'b1) begin bad++; $display("FAIL reset_load got=%b want=1", o_load); end
    total++; if (o_d_in !== 8'h00 || o_inc !== 1'b0) begin bad++; $display("FAIL reset_dinc got=%h/%b want=00/0", o_d_in, o_inc); end
    reset_n = 1;
  endtask

  task automatic test_reset_mid_run();
    int t0, n;
    @(negedge clk);
    i_req = 2'b01; i_op = 2'b01; i_start0 = 8'h10; i_len0 = 4'd5; t0 = cyc;
    while (cyc < t0 + 4) @(negedge clk);
    total++; if (o_grant !== 2'b01 || o_inc !== 1'b1) begin bad++; $display("FAIL midrun_active got=%b/%b want=01/1", o_grant, o_inc); end
    #1 reset_n = 0;
    #1;
    total++; if (o_grant !== 2'b00) begin bad++; $display("FAIL midrun_grant got=%b want=00", o_grant); end
    total++; if (o_done !== 2'b00 || o_result !== 8'h00) begin bad++; $display("FAIL midrun_clear got=%b/%h want=00/00", o_done, o_result); end
    i_req = 0;
    @(negedge clk);
    reset_n = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_done != 0) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL midrun_nodone got=%0d want=0", n); end
    total++; if (o_grant !== 2'b00 || o_load !== 1'b1) begin bad++; $display("FAIL midrun_idle got=%b/%b want=00/1", o_grant, o_load); end
  endtask

  task automatic test_single0();
    int t0, n;
    bit got;
    exp_t e;
    @(negedge clk);
    i_req = 2'b01; i_op = 2'b01; i_start0 = 8'h10; i_len0 = 4'd3; t0 = cyc;
    sb.push_back('{2'b01, 8'h13, t0 + 6});
    @(negedge clk);
    total++; if (o_grant !== 2'b01) begin bad++; $display("FAIL s0_grant got=%b want=01", o_grant); end
    total++; if (o_load !== 1'b1 || o_d_in !== 8'h10) begin bad++; $display("FAIL s0_load got=%b/%h want=1/10", o_load, o_d_in); end
    i_req = 0;
    n = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_inc === 1'b1) n++;
      got = (o_done != 0);
    end
    total++; if (n !== 3) begin bad++; $display("FAIL s0_inc_cycles got=%0d want=3", n); end
    if (!got) begin total++; bad++; $display("FAIL s0_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      total++; if (o_done !== e.m) begin bad++; $display("FAIL s0_done got=%b want=%b", o_done, e.m); end
      total++; if (o_result !== e.r) begin bad++; $display("FAIL s0_result got=%h want=%h", o_result, e.r); end
      total++; if (cyc !== e.t) begin bad++; $display("FAIL s0_latency got=%0d want=%0d", cyc, e.t); end
    end
    repeat (2) @(negedge clk);
    total++; if (cnt !== 8'h13) begin bad++; $display("FAIL s0_hold_cnt got=%h want=13", cnt); end
    total++; if (o_load !== 1'b1 || o_d_in !== 8'h13) begin bad++; $display("FAIL s0_hold_din got=%b/%h want=1/13", o_load, o_d_in); end
  endtask

  task automatic test_single1_wrap();
    int t0;
    bit got;
    exp_t e;
    @(negedge clk);
    i_req = 2'b10; i_op = 2'b00; i_start1 = 8'h01; i_len1 = 4'd3; t0 = cyc;
    sb.push_back('{2'b10, 8'hFE, t0 + 6});
    @(negedge clk);
    i_req = 0;
    wait_done(20, got);
    if (!got) begin total++; bad++; $display("FAIL wrap_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      total++; if (o_done !== e.m) begin bad++; $display("FAIL wrap_done got=%b want=%b", o_done, e.m); end
      total++; if (o_result !== e.r) begin bad++; $display("FAIL wrap_result got=%h want=%h", o_result, e.r); end
      total++; if (cyc !== e.t) begin bad++; $display("FAIL wrap_latency got=%0d want=%0d", cyc, e.t); end
    end
  endtask

  task automatic test_len0();
    int t0;
    bit got;
    exp_t e;
    @(negedge clk);
    i_req = 2'b01; i_op = 2'b01; i_start0 = 8'hA5; i_len0 = 4'd0; t0 = cyc;
    sb.push_back('{2'b01, 8'hA5, t0 + 3});
    @(negedge clk);
    i_req = 0;
    wait_done(20, got);
    if (!got) begin total++; bad++; $display("FAIL len0_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      total++; if (o_done !== e.m) begin bad++; $display("FAIL len0_done got=%b want=%b", o_done, e.m); end
      total++; if (o_result !== e.r) begin bad++; $display("FAIL len0_result got=%h want=%h", o_result, e.r); end
      total++; if (cyc !== e.t) begin bad++; $display("FAIL len0_latency got=%0d want=%0d", cyc, e.t); end
    end
  endtask

  task automatic test_drop_req();
    int t0;
    bit got;
    exp_t e;
    @(negedge clk);
    i_req = 2'b01; i_op = 2'b11; i_start0 = 8'hF0; i_len0 = 4'd4; i_start1 = 8'h20; i_len1 = 4'd2; t0 = cyc;
    sb.push_back('{2'b01, 8'hF4, t0 + 7});
    sb.push_back('{2'b10, 8'h22, t0 + 12});
    repeat (3) @(negedge clk);
    i_req = 2'b10; i_op = 2'b10; i_start0 = 8'h00; i_len0 = 4'd1;
    wait_done(20, got);
    if (!got) begin total++; bad++; $display("FAIL drop_timeout0 got=none want=done"); end
    else begin
      e = sb.pop_front();
      total++; if (o_done !== e.m) begin bad++; $display("FAIL drop_done0 got=%b want=%b", o_done, e.m); end
      total++; if (o_result !== e.r) begin bad++; $display("FAIL drop_result0 got=%h want=%h", o_result, e.r); end
      total++; if (cyc !== e.t) begin bad++; $display("FAIL drop_latency0 got=%0d want=%0d", cyc, e.t); end
    end
    @(negedge clk);
    total++; if (o_grant !== 2'b10) begin bad++; $display("FAIL drop_grant1 got=%b want=10", o_grant); end
    i_req = 0;
    wait_done(20, got);
    if (!got) begin total++; bad++; $display("FAIL drop_timeout1 got=none want=done"); end
    else begin
      e = sb.pop_front();
      total++; if (o_done !== e.m) begin bad++; $display("FAIL drop_done1 got=%b want=%b", o_done, e.m); end
      total++; if (o_result !== e.r) begin bad++; $display("FAIL drop_result1 got=%h want=%h", o_result, e.r); end
      total++; if (cyc !== e.t) begin bad++; $display("FAIL drop_latency1 got=%0d want=%0d", cyc, e.t); end
    end
  endtask

  task automatic test_alternate();
    int t0;
    bit got;
    exp_t e;
    do_reset();
    i_req = 2'b11; i_op = 2'b11; i_start0 = 8'h00; i_start1 = 8'h80; i_len0 = 4'd1; i_len1 = 4'd1; t0 = cyc;
    for (int k = 0; k < 4; k++) sb.push_back('{(k % 2) ? 2'b10 : 2'b01, (k % 2) ? 8'h81 : 8'h01, t0 + 4 * (k + 1)});
    @(negedge clk);
    total++; if (o_grant !== 2'b01) begin bad++; $display("FAIL alt_first_grant got=%b want=01", o_grant); end
    for (int k = 0; k < 4; k++) begin
      wait_done(12, got);
      if (!got) begin total++; bad++; $display("FAIL alt_timeout%0d got=none want=done", k); end
      else begin
        e = sb.pop_front();
        total++; if (o_done !== e.m) begin bad++; $display("FAIL alt_done%0d got=%b want=%b", k, o_done, e.m); end
        total++; if (o_result !== e.r) begin bad++; $display("FAIL alt_result%0d got=%h want=%h", k, o_result, e.r); end
        total++; if (cyc !== e.t) begin bad++; $display("FAIL alt_time%0d got=%0d want=%0d", k, cyc, e.t); end
      end
    end
    i_req = 0;
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL alt_sb_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_single0();
    test_single1_wrap();
    test_len0();
    test_drop_req();
    test_alternate();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
